// File: rtl/loop_trace_monitor.sv
// Passive trace checker for the selector-gated i/j loop counter (i+=2, j-=1 while sel && j>=i).
// Optional stall counter is built only when LOOP_MON_STALL_EN is defined.
module loop_trace_monitor #(
  parameter int W      = 15,
  parameter int I_INIT = 1,
  parameter int J_INIT = 1000,
  parameter int I_TERM = 669,
  parameter int J_TERM = 666
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dut_rst,
  input  logic         dut_sel,
  input  logic [W-1:0] dut_i,
  input  logic [W-1:0] dut_j,
  output logic         armed,
  output logic         done,
  output logic         term_ok,
  output logic         err,
  output logic [2:0]   err_code,
  output logic [W-1:0] step_cnt,
  output logic [W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    S_WAIT_RST = 3'd0,
    S_ARM      = 3'd1,
    S_TRACK    = 3'd2,
    S_DONE     = 3'd3,
    S_FAIL     = 3'd4
  } state_t;

  localparam logic [2:0]   C_NONE   = 3'd0;
  localparam logic [2:0]   C_STEP   = 3'd1;
  localparam logic [2:0]   C_PROP   = 3'd2;
  localparam logic [2:0]   C_RST    = 3'd4;
  localparam logic [W-1:0] L_I_INIT = W'(I_INIT);
  localparam logic [W-1:0] L_J_INIT = W'(J_INIT);
  localparam logic [W-1:0] L_I_TERM = W'(I_TERM);
  localparam logic [W-1:0] L_J_TERM = W'(J_TERM);

  function automatic logic [W-1:0] f_sat_inc(input logic [W-1:0] v);
    if (v == {W{1'b1}}) begin
      return v;
    end else begin
      return v + W'(1);
    end
  endfunction

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_prev_i, r_prev_j;
  logic           r_prev_sel;
  logic           r_armed, r_done, r_term_ok, r_err;
  logic [2:0]     r_err_code;
  logic [W-1:0]   r_step_cnt;

  logic           w_adv;
  logic [W-1:0]   w_exp_i, w_exp_j;
  logic           w_init_bad, w_step_bad, w_prop_bad;
  logic [2:0]     w_fault_code;
  logic           w_fault;
  logic           w_armed_nxt, w_done_nxt, w_term_nxt, w_err_nxt;
  logic [2:0]     w_code_nxt;
  logic [W-1:0]   w_step_nxt, w_prev_i_nxt, w_prev_j_nxt;
  logic           w_prev_sel_nxt;

  assign w_exp_i    = w_adv ? (r_prev_i + W'(2)) : r_prev_i;
  assign w_exp_j    = w_adv ? (r_prev_j - W'(1)) : r_prev_j;
  assign w_init_bad = (dut_i != L_I_INIT) || (dut_j != L_J_INIT);
  assign w_step_bad = (dut_i != w_exp_i) || (dut_j != w_exp_j);
  assign w_prop_bad = (dut_i > dut_j) && (dut_j != L_J_TERM);
  assign w_fault    = (w_fault_code != C_NONE);

  // Classify the current sample; a step mismatch outranks a property breach.
  always_comb begin
    w_adv        = 1'b0;
    w_fault_code = C_NONE;
    if (r_state == S_TRACK) begin
      w_adv = r_prev_sel && (r_prev_j >= r_prev_i);
    end else begin
      w_adv = 1'b0;
    end
    case (r_state)
      S_ARM: begin
        if (w_init_bad) w_fault_code = C_RST;
        else            w_fault_code = C_NONE;
      end
      S_TRACK, S_DONE: begin
        if (w_step_bad)      w_fault_code = C_STEP;
        else if (w_prop_bad) w_fault_code = C_PROP;
        else                 w_fault_code = C_NONE;
      end
      default: w_fault_code = C_NONE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_WAIT_RST;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; FAIL is left only through rst.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_RST: begin
        if (dut_rst) w_state_nxt = S_ARM;
        else         w_state_nxt = S_WAIT_RST;
      end
      S_ARM: begin
        if (w_fault)      w_state_nxt = S_FAIL;
        else if (dut_rst) w_state_nxt = S_ARM;
        else              w_state_nxt = S_TRACK;
      end
      S_TRACK: begin
        if (w_fault)            w_state_nxt = S_FAIL;
        else if (dut_rst)       w_state_nxt = S_ARM;
        else if (dut_j < dut_i) w_state_nxt = S_DONE;
        else                    w_state_nxt = S_TRACK;
      end
      S_DONE: begin
        if (w_fault)      w_state_nxt = S_FAIL;
        else if (dut_rst) w_state_nxt = S_ARM;
        else              w_state_nxt = S_DONE;
      end
      S_FAIL:  w_state_nxt = S_FAIL;
      default: w_state_nxt = S_WAIT_RST;
    endcase
  end

  // Output and history decisions, registered below.
  always_comb begin
    w_armed_nxt    = (w_state_nxt == S_ARM) || (w_state_nxt == S_TRACK) || (w_state_nxt == S_DONE);
    w_done_nxt     = (w_state_nxt == S_DONE);
    w_err_nxt      = r_err;
    w_code_nxt     = r_err_code;
    w_step_nxt     = r_step_cnt;
    w_prev_i_nxt   = r_prev_i;
    w_prev_j_nxt   = r_prev_j;
    w_prev_sel_nxt = r_prev_sel;
    if (w_state_nxt != S_DONE) begin
      w_term_nxt = 1'b0;
    end else if (r_state == S_TRACK) begin
      w_term_nxt = (dut_i == L_I_TERM) && (dut_j == L_J_TERM);
    end else begin
      w_term_nxt = r_term_ok;
    end
    if (w_fault) begin
      w_err_nxt  = 1'b1;
      w_code_nxt = w_fault_code;
    end else if (r_state == S_ARM) begin
      w_step_nxt     = '0;
      w_prev_i_nxt   = dut_i;
      w_prev_j_nxt   = dut_j;
      w_prev_sel_nxt = dut_sel;
    end else if (r_state == S_TRACK) begin
      if (w_adv) w_step_nxt = f_sat_inc(r_step_cnt);
      else       w_step_nxt = r_step_cnt;
      w_prev_i_nxt   = dut_i;
      w_prev_j_nxt   = dut_j;
      w_prev_sel_nxt = dut_sel;
    end else begin
      w_step_nxt = r_step_cnt;
    end
  end

  // Registered outputs and sample history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed    <= 1'b0;
      r_done     <= 1'b0;
      r_term_ok  <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 3'd0;
      r_step_cnt <= '0;
      r_prev_i   <= '0;
      r_prev_j   <= '0;
      r_prev_sel <= 1'b0;
    end else begin
      r_armed    <= w_armed_nxt;
      r_done     <= w_done_nxt;
      r_term_ok  <= w_term_nxt;
      r_err      <= w_err_nxt;
      r_err_code <= w_code_nxt;
      r_step_cnt <= w_step_nxt;
      r_prev_i   <= w_prev_i_nxt;
      r_prev_j   <= w_prev_j_nxt;
      r_prev_sel <= w_prev_sel_nxt;
    end
  end

`ifdef LOOP_MON_STALL_EN
  logic [W-1:0] r_stall_cnt;
  logic [W-1:0] w_stall_nxt;

  // Count legal held cycles while tracking.
  always_comb begin
    w_stall_nxt = r_stall_cnt;
    if (w_fault) begin
      w_stall_nxt = r_stall_cnt;
    end else if (r_state == S_ARM) begin
      w_stall_nxt = '0;
    end else if ((r_state == S_TRACK) && !w_adv) begin
      w_stall_nxt = f_sat_inc(r_stall_cnt);
    end else begin
      w_stall_nxt = r_stall_cnt;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) r_stall_cnt <= '0;
    else     r_stall_cnt <= w_stall_nxt;
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

  assign armed    = r_armed;
  assign done     = r_done;
  assign term_ok  = r_term_ok;
  assign err      = r_err;
  assign err_code = r_err_code;
  assign step_cnt = r_step_cnt;

endmodule

// File: tb/tb_loop_trace_monitor.sv
// Bench for loop_trace_monitor: a vector table for short sequences plus a counter model
// driving long golden runs and targeted fault injections.
module tb_loop_trace_monitor;

`ifdef LOOP_MON_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dut_rst = 1'b0;
  logic        dut_sel = 1'b0;
  logic [14:0] dut_i = 15'd0;
  logic [14:0] dut_j = 15'd0;
  logic        armed, done, term_ok, err;
  logic [2:0]  err_code;
  logic [14:0] step_cnt, stall_cnt;

  int checks = 0;
  int failures = 0;
  logic [14:0] mi = 15'd0;
  logic [14:0] mj = 15'd0;

  loop_trace_monitor dut (
    .clk(clk), .rst(rst), .dut_rst(dut_rst), .dut_sel(dut_sel),
    .dut_i(dut_i), .dut_j(dut_j), .armed(armed), .done(done),
    .term_ok(term_ok), .err(err), .err_code(err_code),
    .step_cnt(step_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, drst, sel;
    logic [14:0] i, j;
    logic        armed, done, term, err;
    logic [2:0]  code;
    logic [14:0] step, stall;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic dr, input logic s, input int i, input int j,
                              input logic a, input logic d, input logic t, input logic e,
                              input int c, input int st, input int sl);
    vec_t v;
    v.rst = r; v.drst = dr; v.sel = s; v.i = 15'(i); v.j = 15'(j);
    v.armed = a; v.done = d; v.term = t; v.err = e; v.code = 3'(c);
    v.step = 15'(st); v.stall = STALL_ON ? 15'(sl) : 15'd0;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_rst();
    rst = 1'b1; dut_rst = 1'b0; dut_sel = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One cycle of a golden counter: present its current output, then advance it.
  task automatic gcycle(input logic r, input logic s);
    rst = 1'b0; dut_rst = r; dut_sel = s; dut_i = mi; dut_j = mj;
    @(posedge clk);
    if (r) begin
      mi = 15'd1; mj = 15'd1000;
    end else if (s && (mj >= mi)) begin
      mi = mi + 15'd2; mj = mj - 15'd1;
    end else begin
      mi = mi;
    end
    #1;
  endtask

  vec_t tbl[22];
  int   done_at;
  bit   found;

  initial begin
    //             rst drst sel  i    j     arm dn tm er cd stp stl
    tbl[0]  = mk(1, 0, 0,   0,    0,  0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1,   7,    7,  0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 123,   45,  1, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 1,   1, 1000,  1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 1,   3,  999,  1, 0, 0, 0, 0, 1, 0);
    tbl[5]  = mk(0, 0, 0,   5,  998,  1, 0, 0, 0, 0, 2, 0);
    tbl[6]  = mk(0, 0, 1,   5,  998,  1, 0, 0, 0, 0, 2, 1);
    tbl[7]  = mk(0, 0, 1,   7,  997,  1, 0, 0, 0, 0, 3, 1);
    tbl[8]  = mk(0, 1, 1,   9,  996,  1, 0, 0, 0, 0, 4, 1);
    tbl[9]  = mk(0, 0, 1,   1, 1000,  1, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 1,   3,  999,  1, 0, 0, 0, 0, 1, 0);
    tbl[11] = mk(0, 0, 1,   5,  999,  0, 0, 0, 1, 1, 1, 0);
    tbl[12] = mk(0, 1, 1,   1, 1000,  0, 0, 0, 1, 1, 1, 0);
    tbl[13] = mk(1, 0, 0,   0,    0,  0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 1, 0,   0,    0,  1, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, 0,   2, 1000,  0, 0, 0, 1, 4, 0, 0);
    tbl[16] = mk(1, 0, 0,   0,    0,  0, 0, 0, 0, 0, 0, 0);
    tbl[17] = mk(0, 1, 0,   9,    9,  1, 0, 0, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, 0,   1, 1000,  1, 0, 0, 0, 0, 0, 0);
    tbl[19] = mk(0, 0, 0,   1, 1000,  1, 0, 0, 0, 0, 0, 1);
    tbl[20] = mk(0, 0, 1,   1, 1000,  1, 0, 0, 0, 0, 0, 2);
    tbl[21] = mk(0, 0, 1,   3,  999,  1, 0, 0, 0, 0, 1, 2);

    for (int n = 0; n < 22; n++) begin
      rst = tbl[n].rst; dut_rst = tbl[n].drst; dut_sel = tbl[n].sel;
      dut_i = tbl[n].i; dut_j = tbl[n].j;
      @(posedge clk); #1;
      chk($sformatf("v%0d.armed", n), int'(armed), int'(tbl[n].armed));
      chk($sformatf("v%0d.done", n), int'(done), int'(tbl[n].done));
      chk($sformatf("v%0d.term_ok", n), int'(term_ok), int'(tbl[n].term));
      chk($sformatf("v%0d.err", n), int'(err), int'(tbl[n].err));
      chk($sformatf("v%0d.err_code", n), int'(err_code), int'(tbl[n].code));
      chk($sformatf("v%0d.step_cnt", n), int'(step_cnt), int'(tbl[n].step));
      chk($sformatf("v%0d.stall_cnt", n), int'(stall_cnt), int'(tbl[n].stall));
    end

    // Full golden run with sel held high.
    do_rst();
    gcycle(1'b1, 1'b1);
    done_at = -1;
    for (int k = 0; k < 400; k++) begin
      gcycle(1'b0, 1'b1);
      if (done && (done_at < 0)) done_at = k;
    end
    chk("run1.done_at", done_at, 334);
    chk("run1.done", int'(done), 1);
    chk("run1.step_cnt", int'(step_cnt), 334);
    chk("run1.term_ok", int'(term_ok), 1);
    chk("run1.err", int'(err), 0);
    chk("run1.stall_cnt", int'(stall_cnt), 0);
    // A change while DONE is a step fault.
    rst = 1'b0; dut_rst = 1'b0; dut_sel = 1'b1; dut_i = 15'd671; dut_j = 15'd665;
    @(posedge clk); #1;
    chk("done_move.err_code", int'(err_code), 1);
    chk("done_move.done", int'(done), 0);
    chk("done_move.term_ok", int'(term_ok), 0);

    // Alternating selector, starting low at the ARM sample.
    do_rst();
    gcycle(1'b1, 1'b0);
    for (int k = 0; k < 800; k++) gcycle(1'b0, (k % 2) == 1);
    chk("run2.done", int'(done), 1);
    chk("run2.step_cnt", int'(step_cnt), 334);
    chk("run2.stall_cnt", int'(stall_cnt), STALL_ON ? 334 : 0);
    chk("run2.err", int'(err), 0);
    chk("run2.term_ok", int'(term_ok), 1);
    gcycle(1'b1, 1'b1);
    chk("run2.rearm", int'(armed), 1);
    chk("run2.term_cleared", int'(term_ok), 0);

    // DUT reset mid-run after 100 steps, then a clean re-track.
    do_rst();
    gcycle(1'b1, 1'b1);
    for (int k = 0; k < 101; k++) gcycle(1'b0, 1'b1);
    chk("run5.step100", int'(step_cnt), 100);
    gcycle(1'b1, 1'b1);
    chk("run5.armed", int'(armed), 1);
    chk("run5.step_at_rst", int'(step_cnt), 101);
    gcycle(1'b0, 1'b1);
    chk("run5.step_zero", int'(step_cnt), 0);
    chk("run5.err_mid", int'(err), 0);
    for (int k = 0; k < 400; k++) gcycle(1'b0, 1'b1);
    chk("run5.done", int'(done), 1);
    chk("run5.step_cnt", int'(step_cnt), 334);
    chk("run5.term_ok", int'(term_ok), 1);
    chk("run5.err", int'(err), 0);

    // Step fault that also breaks the terminal property reports code 1.
    do_rst();
    gcycle(1'b1, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ((mi == 15'd667) && (mj == 15'd667)) begin
        found = 1'b1;
        break;
      end
      gcycle(1'b0, 1'b1);
    end
    chk("run6.reached", int'(found), 1);
    gcycle(1'b0, 1'b1);
    chk("run6.step333", int'(step_cnt), 333);
    chk("run6.err_before", int'(err), 0);
    rst = 1'b0; dut_rst = 1'b0; dut_sel = 1'b1; dut_i = 15'd670; dut_j = 15'd665;
    @(posedge clk); #1;
    chk("run6.err", int'(err), 1);
    chk("run6.err_code", int'(err_code), 1);
    chk("run6.armed", int'(armed), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
